// File: rtl/tpm_loc_pkg.sv
// tpm_loc_pkg: shared types, widths and helper functions for the TPM locality arbiter.
`default_nettype none

package tpm_loc_pkg;

  localparam int         LOC_W    = 3;
  localparam logic [7:0] LOC_NONE = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  function automatic logic [7:0] loc_onehot(input logic [LOC_W-1:0] idx);
    return 8'h01 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tpm_loc_prio_enc.sv
// tpm_loc_prio_enc: finds the highest set bit of an N-bit vector.
`default_nettype none

module tpm_loc_prio_enc
  import tpm_loc_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0]     vec,
  output logic             valid,
  output logic [LOC_W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = LOC_W'(i);
    end
  end

  assign valid = |vec;

endmodule

`default_nettype wire

// File: rtl/tpm_locality_arbiter.sv
// tpm_locality_arbiter: decides which TPM locality owns the register space and CRB.
// Seize support is built only when TPM_LOC_SEIZE_EN is defined.
`default_nettype none

module tpm_locality_arbiter
  import tpm_loc_pkg::*;
#(
  parameter int NUM_LOC = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_LOC-1:0] req_use,
  input  logic [NUM_LOC-1:0] relinquish,
  input  logic [NUM_LOC-1:0] seize,
  input  logic [NUM_LOC-1:0] clear_seized,
  input  logic               busy,
  output logic               active_valid,
  output logic [LOC_W-1:0]   active_loc,
  output logic [7:0]         locality_out,
  output logic [NUM_LOC-1:0] pending,
  output logic [NUM_LOC-1:0] been_seized,
  output logic               grant_pulse
);

  state_t             state_q, state_d;
  logic [LOC_W-1:0]   own_q, own_d;
  logic [NUM_LOC-1:0] pend_q, pend_d;
  logic [NUM_LOC-1:0] pend_avail;
  logic               pend_v;
  logic [LOC_W-1:0]   pend_idx;
  logic               rel_own;
  logic               handover;
  logic               tgt_v;
  logic [LOC_W-1:0]   tgt_idx;
  logic               seized_handover;
  logic               sz_cand_v;
  logic [LOC_W-1:0]   sz_cand_idx;
  logic               rel_seen_eff;

  // A request cancelled in the same cycle must not be granted.
  assign pend_avail = pend_q & ~relinquish;

  tpm_loc_prio_enc #(.N(NUM_LOC)) u_pend_enc (
    .vec   (pend_avail),
    .valid (pend_v),
    .idx   (pend_idx)
  );

`ifdef TPM_LOC_SEIZE_EN
  logic [NUM_LOC-1:0] sz_vec;
  logic               sz_v;
  logic [LOC_W-1:0]   sz_idx;
  logic               sz_lat_v;
  logic [LOC_W-1:0]   sz_lat_idx;
  logic               rel_seen_q;
  logic [NUM_LOC-1:0] been_q;

  always_comb begin
    sz_vec = '0;
    for (int i = 0; i < NUM_LOC; i++) begin
      sz_vec[i] = seize[i] && (state_q != S_IDLE) && (LOC_W'(i) > own_q);
    end
  end

  tpm_loc_prio_enc #(.N(NUM_LOC)) u_seize_enc (
    .vec   (sz_vec),
    .valid (sz_v),
    .idx   (sz_idx)
  );

  always_comb begin
    sz_cand_v   = sz_lat_v;
    sz_cand_idx = sz_lat_idx;
    if (sz_v && (!sz_lat_v || sz_idx > sz_lat_idx)) begin
      sz_cand_v   = 1'b1;
      sz_cand_idx = sz_idx;
    end
  end

  assign rel_seen_eff = rel_seen_q | rel_own;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sz_lat_v   <= 1'b0;
      sz_lat_idx <= '0;
      rel_seen_q <= 1'b0;
      been_q     <= '0;
    end else begin
      if (handover || state_d != S_DRAIN) begin
        sz_lat_v   <= 1'b0;
        sz_lat_idx <= '0;
        rel_seen_q <= 1'b0;
      end else begin
        sz_lat_v   <= sz_cand_v;
        sz_lat_idx <= sz_cand_idx;
        rel_seen_q <= rel_seen_eff;
      end
      // A seize in the same cycle as a clear leaves the bit set.
      for (int i = 0; i < NUM_LOC; i++) begin
        if (seized_handover && own_q == LOC_W'(i)) been_q[i] <= 1'b1;
        else if (clear_seized[i])                  been_q[i] <= 1'b0;
      end
    end
  end

  assign been_seized = been_q;
`else
  logic unused_seize;
  assign unused_seize = ^{seize, clear_seized};
  assign sz_cand_v    = 1'b0;
  assign sz_cand_idx  = '0;
  assign rel_seen_eff = 1'b0;
  assign been_seized  = '0;
`endif

  always_comb begin
    state_d         = state_q;
    own_d           = own_q;
    pend_d          = pend_q;
    rel_own         = 1'b0;
    handover        = 1'b0;
    tgt_v           = 1'b0;
    tgt_idx         = '0;
    seized_handover = 1'b0;

    for (int i = 0; i < NUM_LOC; i++) begin
      if ((state_q != S_IDLE) && (own_q == LOC_W'(i))) begin
        rel_own = rel_own | relinquish[i];
      end else if (relinquish[i]) begin
        pend_d[i] = 1'b0;
      end else if (req_use[i]) begin
        pend_d[i] = 1'b1;
      end
    end

    case (state_q)
      S_IDLE:   handover = pend_v;
      S_ACTIVE: begin
        if (rel_own || sz_cand_v) begin
          if (busy) state_d  = S_DRAIN;
          else      handover = 1'b1;
        end
      end
      S_DRAIN:  handover = !busy;
      default:  state_d = S_IDLE;
    endcase

    if (handover) begin
      if (sz_cand_v) begin
        tgt_v           = 1'b1;
        tgt_idx         = sz_cand_idx;
        seized_handover = !rel_seen_eff;
      end else if (pend_v) begin
        tgt_v   = 1'b1;
        tgt_idx = pend_idx;
      end
      state_d = tgt_v ? S_ACTIVE : S_IDLE;
      own_d   = tgt_idx;
      for (int i = 0; i < NUM_LOC; i++) begin
        if (tgt_v && tgt_idx == LOC_W'(i)) pend_d[i] = 1'b0;
      end
    end
  end

  // Status outputs trail the ownership register by one cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      own_q        <= '0;
      pend_q       <= '0;
      active_valid <= 1'b0;
      active_loc   <= '0;
      locality_out <= LOC_NONE;
      grant_pulse  <= 1'b0;
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      pend_q       <= pend_d;
      active_valid <= (state_q != S_IDLE);
      active_loc   <= own_q;
      locality_out <= (state_q != S_IDLE) ? loc_onehot(own_q) : LOC_NONE;
      grant_pulse  <= ((state_q != S_IDLE) != active_valid) || (own_q != active_loc);
    end
  end

  assign pending = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_tpm_locality_arbiter.sv
// Directed self-checking bench for tpm_locality_arbiter (seize expectations follow TPM_LOC_SEIZE_EN).
`default_nettype none

module tb_tpm_locality_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] req_use, relinquish, seize, clear_seized;
  logic       busy;
  logic       active_valid;
  logic [2:0] active_loc;
  logic [7:0] locality_out;
  logic [4:0] pending, been_seized;
  logic       grant_pulse;

  int vectors = 0;
  int miscompares = 0;

`ifdef TPM_LOC_SEIZE_EN
  localparam logic [4:0] OWN_AFTER_SEIZE = 5'b01000;
  localparam logic [7:0] OUT_AFTER_SEIZE = 8'h08;
  localparam logic [4:0] BEEN_AFTER_SEIZE = 5'b00010;
`else
  localparam logic [4:0] OWN_AFTER_SEIZE = 5'b00010;
  localparam logic [7:0] OUT_AFTER_SEIZE = 8'h02;
  localparam logic [4:0] BEEN_AFTER_SEIZE = 5'b00000;
`endif

  tpm_locality_arbiter #(.NUM_LOC(5)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_use      (req_use),
    .relinquish   (relinquish),
    .seize        (seize),
    .clear_seized (clear_seized),
    .busy         (busy),
    .active_valid (active_valid),
    .active_loc   (active_loc),
    .locality_out (locality_out),
    .pending      (pending),
    .been_seized  (been_seized),
    .grant_pulse  (grant_pulse)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input logic [4:0] ru, input logic [4:0] rl,
                       input logic [4:0] sz, input logic [4:0] cs);
    req_use = ru; relinquish = rl; seize = sz; clear_seized = cs;
    tick();
    req_use = '0; relinquish = '0; seize = '0; clear_seized = '0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"},   {7'd0, active_valid}, 8'h00);
    check({tag, ".loc"},     {5'd0, active_loc},   8'h00);
    check({tag, ".onehot"},  locality_out,         8'h00);
    check({tag, ".pending"}, {3'd0, pending},      8'h00);
    check({tag, ".seized"},  {3'd0, been_seized},  8'h00);
    check({tag, ".grant"},   {7'd0, grant_pulse},  8'h00);
  endtask

  initial begin
    reset_n = 1'b0; busy = 1'b0;
    req_use = '0; relinquish = '0; seize = '0; clear_seized = '0;
    tick(); tick();
    reset_n = 1'b1;
    check_all_zero("reset");

    // 1: request from loc0 while idle
    apply(5'b00001, 5'b0, 5'b0, 5'b0);
    check("t1.pend_set", {3'd0, pending}, 8'h01);
    check("t1.valid_early", {7'd0, active_valid}, 8'h00);
    tick();
    check("t1.pend_clr", {3'd0, pending}, 8'h00);
    check("t1.not_yet", {7'd0, active_valid}, 8'h00);
    tick();
    check("t1.valid", {7'd0, active_valid}, 8'h01);
    check("t1.loc", {5'd0, active_loc}, 8'h00);
    check("t1.onehot", locality_out, 8'h01);
    check("t1.grant", {7'd0, grant_pulse}, 8'h01);
    tick();
    check("t1.grant_once", {7'd0, grant_pulse}, 8'h00);

    // 2: own request ignored, others pend, relinquish hands to highest
    apply(5'b00001, 5'b0, 5'b0, 5'b0);
    check("t2.own_req", {3'd0, pending}, 8'h00);
    apply(5'b10100, 5'b0, 5'b0, 5'b0);
    check("t2.pending", {3'd0, pending}, 8'h14);
    apply(5'b0, 5'b00001, 5'b0, 5'b0);
    check("t2.pend_after", {3'd0, pending}, 8'h04);
    tick();
    check("t2.onehot", locality_out, 8'h10);
    check("t2.loc", {5'd0, active_loc}, 8'h04);
    check("t2.grant", {7'd0, grant_pulse}, 8'h01);

    // 3: reach loc1, then seize from loc3 while busy
    apply(5'b00010, 5'b0, 5'b0, 5'b0);
    apply(5'b0, 5'b10000, 5'b0, 5'b0);
    tick();
    check("t3.to_loc2", locality_out, 8'h04);
    apply(5'b0, 5'b00100, 5'b0, 5'b0);
    tick();
    check("t3.loc1", locality_out, 8'h02);
    busy = 1'b1;
    apply(5'b0, 5'b0, 5'b01000, 5'b0);
    tick(); tick();
    check("t3.drain_hold", locality_out, 8'h02);
    check("t3.drain_seized", {3'd0, been_seized}, 8'h00);
    busy = 1'b0;
    tick(); tick();
    check("t3.after_busy", locality_out, OUT_AFTER_SEIZE);
    check("t3.been_seized", {3'd0, been_seized}, {3'd0, BEEN_AFTER_SEIZE});
    apply(5'b0, 5'b0, 5'b0, 5'b00010);
    check("t3.cleared", {3'd0, been_seized}, 8'h00);

    // 4: low/equal seizes ignored, seize in idle ignored
    apply(5'b0, OWN_AFTER_SEIZE, 5'b0, 5'b0);
    tick();
    check("t4.idle", {7'd0, active_valid}, 8'h00);
    check("t4.idle_grant", {7'd0, grant_pulse}, 8'h01);
    apply(5'b01000, 5'b0, 5'b0, 5'b0);
    tick(); tick();
    check("t4.loc3", locality_out, 8'h08);
    apply(5'b0, 5'b0, 5'b01010, 5'b0);
    tick(); tick();
    check("t4.ignored", locality_out, 8'h08);
    check("t4.no_seized", {3'd0, been_seized}, 8'h00);
    apply(5'b0, 5'b01000, 5'b0, 5'b0);
    tick();
    apply(5'b0, 5'b0, 5'b10000, 5'b0);
    tick(); tick();
    check("t4.idle_seize", {7'd0, active_valid}, 8'h00);

    // 5: same-cycle request/cancel, then release to none
    apply(5'b00100, 5'b0, 5'b0, 5'b0);
    tick(); tick();
    check("t5.loc2", locality_out, 8'h04);
    apply(5'b10000, 5'b10000, 5'b0, 5'b0);
    check("t5.cancel_wins", {3'd0, pending}, 8'h00);
    apply(5'b0, 5'b00100, 5'b0, 5'b0);
    tick();
    check("t5.none", locality_out, 8'h00);
    check("t5.grant", {7'd0, grant_pulse}, 8'h01);
    tick();
    check("t5.grant_once", {7'd0, grant_pulse}, 8'h00);

    // 6: reset while ownership is held with busy and a pending request
    apply(5'b00100, 5'b0, 5'b0, 5'b0);
    tick(); tick();
    check("t6.loc2", locality_out, 8'h04);
    busy = 1'b1;
    apply(5'b01000, 5'b0, 5'b10000, 5'b0);
    apply(5'b0, 5'b00100, 5'b0, 5'b0);
    tick();
    check("t6.held", locality_out, 8'h04);
    check("t6.pend", {3'd0, pending}, 8'h08);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    busy = 1'b0;
    check_all_zero("t6.reset");
    tick();
    check("t6.stay_idle", {7'd0, active_valid}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
